uart_tx_arbiter: RTL

//  Shares the single UartTx serializer among NREQ byte producers (CPU console, loader status, debug).

---
 rtl/uart_tx_arbiter_pkg.sv | 13 +
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter_rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [7:0]  UA_LF     = 8'h0A;
  localparam int unsigned UA_MAXREQ = 4;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Producer/serializer bundle for the UART transmit arbiter.
// master: the producers plus UartTx side; slave: the arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NREQ = 2
);
  logic [NREQ-1:0]   REQ_VALID;
  logic [8*NREQ-1:0] REQ_DATA;
  logic [NREQ-1:0]   REQ_READY;
  logic [7:0]        TX_DATA;
  logic              TX_WE;
  logic              TX_READY;
  logic [1:0]        GRANT_ID;
  logic              BUSY;

  modport master (
    output REQ_VALID, REQ_DATA, TX_READY,
    input  REQ_READY, TX_DATA, TX_WE, GRANT_ID, BUSY
  );

  modport slave (
    input  REQ_VALID, REQ_DATA, TX_READY,
    output REQ_READY, TX_DATA, TX_WE, GRANT_ID, BUSY
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first request found starting at
// pointer+1 (mod NREQ) wins.
module uart_rr_pick #(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [1:0]      o_idx,
  output logic            o_any
);

  // Scan offsets 1..NREQ from the pointer; the first live request is granted.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!o_any && i_req[j] && (((32'(i_ptr) + k) % NREQ) == j)) begin
          o_any    = 1'b1;
          o_gnt[j] = 1'b1;
          o_idx    = 2'(j);
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UartTx serializer among NREQ byte
// producers, one byte per grant, paced by the serializer READY.
// Optional line lock: define UART_LINE_LOCK_EN to keep the grant on one
// requester until it sends 8'h0A (or goes idle for LOCK_TIMEOUT cycles).
module uart_tx_arbiter #(
  parameter int unsigned NREQ         = 2,
  parameter int unsigned LOCK_TIMEOUT = 4096
) (
  input logic              CLK,
  input logic              RST_X,
  uart_tx_arbiter_if.slave arb
);
  import uart_tx_arbiter_pkg::*;

  if (NREQ < 2 || NREQ > UA_MAXREQ || LOCK_TIMEOUT == 0) begin : g_bad_cfg
    $error("uart_tx_arbiter: NREQ must be 2..4 and LOCK_TIMEOUT nonzero");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_ptr;
  logic [1:0]        r_grant;
  logic [7:0]        r_tx_data;
  logic              r_tx_we;
  logic [NREQ-1:0]   w_mask;
  logic [NREQ-1:0]   w_req;
  logic [NREQ-1:0]   w_gnt;
  logic [NREQ-1:0]   w_req_ready;
  logic [1:0]        w_idx;
  logic              w_any;
  logic              w_accept;
  logic              w_busy;
  logic [7:0]        w_sel_data;

  assign w_req = arb.REQ_VALID & w_mask;

  uart_rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req (w_req),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Gated by RST_X so no producer is accepted during a reset cycle.
  assign w_accept = RST_X && (r_state == S_IDLE) && arb.TX_READY && w_any;

  // Byte of the winning requester.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (w_gnt[j]) w_sel_data = arb.REQ_DATA[8*j +: 8];
    end
  end

  // Next-state and combinational handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    w_req_ready = w_accept ? w_gnt : '0;
    w_busy      = (r_state != S_IDLE);
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_SEND;
      S_SEND:  w_state_nxt = S_WAIT;
      S_WAIT:  if (arb.TX_READY) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST_X) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Byte capture, grant index, RR pointer and the one-cycle write strobe.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_tx_data <= '0;
      r_grant   <= '0;
      r_ptr     <= 2'(NREQ - 1);
      r_tx_we   <= 1'b0;
    end else begin
      r_tx_we <= w_accept;
      if (w_accept) begin
        r_tx_data <= w_sel_data;
        r_grant   <= w_idx;
        r_ptr     <= w_idx;
      end
    end
  end

`ifdef UART_LINE_LOCK_EN
  localparam int unsigned LCW = $clog2(LOCK_TIMEOUT + 1);

  logic            r_lock;
  logic [1:0]      r_lock_id;
  logic [LCW-1:0]  r_lock_cnt;
  logic [NREQ-1:0] w_lock_oh;
  logic            w_lock_idle;

  // One-hot of the locked requester.
  always_comb begin
    w_lock_oh = '0;
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (2'(j) == r_lock_id) w_lock_oh[j] = 1'b1;
    end
  end

  assign w_mask      = r_lock ? w_lock_oh : '1;
  assign w_lock_idle = r_lock && (r_state == S_IDLE) && arb.TX_READY
                       && !(|(arb.REQ_VALID & w_lock_oh));

  // Lock follows accepted bytes; releases on LF or after the idle timeout.
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_lock     <= 1'b0;
      r_lock_id  <= '0;
      r_lock_cnt <= '0;
    end else if (w_accept) begin
      r_lock_cnt <= '0;
      if (w_sel_data == UA_LF) begin
        r_lock <= 1'b0;
      end else begin
        r_lock    <= 1'b1;
        r_lock_id <= w_idx;
      end
    end else if (w_lock_idle) begin
      if (r_lock_cnt == LCW'(LOCK_TIMEOUT - 1)) begin
        r_lock     <= 1'b0;
        r_lock_cnt <= '0;
      end else begin
        r_lock_cnt <= r_lock_cnt + 1'b1;
      end
    end else begin
      r_lock_cnt <= '0;
    end
  end
`else
  assign w_mask = '1;
`endif

  assign arb.REQ_READY = w_req_ready;
  assign arb.TX_DATA   = r_tx_data;
  assign arb.TX_WE     = r_tx_we;
  assign arb.GRANT_ID  = r_grant;
  assign arb.BUSY      = w_busy;

endmodule
